multicycle_main_fsm: RTL and testbench
======================================

// Module: multicycle_main_fsm
// PURPOSE
//  Main control FSM of the multicycle ARM-subset core; sequences the shared ALU, memory port and register file.
//  Sets the ALU operand muxes and the ALUOp input of ALU_Decoder, which then produces ALUControl and FlagW.
//  Tells the datapath when to fetch, write the IR, advance the PC and write memory or registers.
//  Waits on a memory-ready handshake and counts retired instructions.
// PARAMETERS
//  CNT_W    16   width of the retired-instruction counter (wraps)
// PORTS
//  clk          in   1      single clock, all state updates on rising edge
//  rst_n        in   1      synchronous reset, active-low
//  Op           in   2      instr[27:26]: 00 data-proc, 01 mem, 10 branch, 11 illegal
//  Funct5       in   1      instr[25]: I bit (1 = immediate operand)
//  Funct0       in   1      instr[20]: L bit for mem ops (1 = load)
//  mem_ready    in   1      memory completes the current access this cycle
//  IRWrite      out  1      load instruction register
//  NextPC       out  1      PC write (fetch increment)
//  RegW         out  1      register-file write
//  MemW         out  1      memory write strobe
//  Branch       out  1      branch request (gated by cond logic downstream)
//  AdrSrc       out  1      0 = PC, 1 = ALU result to memory address
//  ALUSrcA      out  1      0 = RD1, 1 = PC
//  ALUSrcB      out  2      00 RD2, 01 ExtImm, 10 const 4
//  ResultSrc    out  2      00 ALUOut, 01 Data, 10 ALUResult
//  ALUOp        out  1      to ALU_Decoder; 1 = decode Funct, 0 = add
//  state        out  4      current state encoding (debug)
//  illegal_op   out  1      Op==11 seen in DECODE
//  instr_done   out  1      one-cycle pulse when an instruction retires
//  instr_cnt    out  CNT_W  retired-instruction count
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 MEMADR=2 MEMREAD=3 MEMWB=4 MEMWRITE=5 EXECR=6 EXECI=7 ALUWB=8 BRANCH=9.
//  Registered state; outputs are combinational from state (Moore), except the mem_ready gating below.
//  Reset (rst_n=0 at an edge): state<=FETCH, instr_cnt<=0.
//   While rst_n=0, all strobes (IRWrite NextPC RegW MemW Branch illegal_op instr_done) are forced to 0.
//  FETCH:    AdrSrc=0 ALUSrcA=1 ALUSrcB=10 ALUOp=0 ResultSrc=10; IRWrite=NextPC=mem_ready.
//            Goes to DECODE when mem_ready=1, else holds.
//  DECODE:   ALUSrcA=1 ALUSrcB=10 ALUOp=0 ResultSrc=10.
//            Next: Op=01->MEMADR; Op=00 with Funct5=0->EXECR, Funct5=1->EXECI; Op=10->BRANCH; Op=11->FETCH with illegal_op=1.
//  MEMADR:   ALUSrcA=0 ALUSrcB=01 ALUOp=0. Funct0=1->MEMREAD, else ->MEMWRITE.
//  MEMREAD:  AdrSrc=1 ResultSrc=00. Goes to MEMWB when mem_ready=1, else holds.
//  MEMWB:    ResultSrc=01 RegW=1 instr_done=1 -> FETCH.
//  MEMWRITE: AdrSrc=1 ResultSrc=00; MemW=mem_ready; instr_done=mem_ready.
//            Goes to FETCH when mem_ready=1, else holds.
//  EXECR:    ALUSrcA=0 ALUSrcB=00 ALUOp=1 -> ALUWB.  EXECI: ALUSrcA=0 ALUSrcB=01 ALUOp=1 -> ALUWB.
//  ALUWB:    ResultSrc=00 RegW=1 instr_done=1 -> FETCH.
//  BRANCH:   ALUSrcA=0 ALUSrcB=01 ALUOp=0 ResultSrc=10 Branch=1 instr_done=1 -> FETCH.
//  Unlisted outputs are 0 in every state.
//  Unused encodings 10-15: all strobes 0, next state FETCH.
//  Latency with no wait states: data-proc/load = 4/5 cycles; store/branch = 4/3 cycles.
//   Each mem_ready=0 cycle adds one cycle.
//  Strobes are single-cycle per instruction even across wait states; MemW is never asserted while mem_ready=0.
//  instr_cnt increments on every instr_done cycle and wraps 2^CNT_W-1 -> 0. illegal_op does not count.
//  Op/Funct are sampled only in DECODE/MEMADR; changes in other states are ignored.
//  rst_n low in any state (including mid-wait) aborts the instruction without a RegW/MemW pulse.
// TESTING
//  ADD reg (Op=00, Funct5=0), mem_ready=1 -> states 0,1,6,8,0; ALUOp=1 in EXECR; RegW only in ALUWB; instr_cnt 0->1.
//  LDR (Op=01, Funct0=1), mem_ready low 2 cycles in MEMREAD -> holds state 3 twice, then 4; one RegW pulse with ResultSrc=01.
//  STR (Op=01, Funct0=0), mem_ready=0 for 3 cycles in MEMWRITE -> MemW=0 for those cycles, then MemW=1 for exactly one cycle.
//  B (Op=10) -> states 0,1,9,0; Branch=1 and ALUSrcB=01 in BRANCH; instr_done=1.
//  Op=11 -> illegal_op pulse in DECODE, back to FETCH, instr_cnt unchanged.
//  rst_n=0 during MEMREAD -> next state FETCH, instr_cnt=0, no RegW. Preload counter to 16'hFFFF and retire one instruction -> wraps to 0.

Source files
------------

// File: rtl/multicycle_main_fsm.sv
// rtl/multicycle_main_fsm.sv - main control FSM of the multicycle ARM-subset core
//
// Sequences fetch, decode, address generation, memory access, execute and
// write-back for a shared ALU / memory port / register file datapath.
//
// Ports:
//   clk, rst_n        clock; synchronous active-low reset
//   Op, Funct5, Funct0 instruction fields (class, I bit, L bit)
//   mem_ready         memory completes the current access this cycle
//   IRWrite, NextPC   fetch strobes (instruction register load, PC advance)
//   RegW, MemW        register-file and memory write strobes
//   Branch            branch request, qualified by condition logic downstream
//   AdrSrc            memory address select (0 PC, 1 ALU result)
//   ALUSrcA, ALUSrcB  ALU operand selects
//   ResultSrc         result bus select
//   ALUOp             to ALU decoder (1 decode Funct, 0 add)
//   state             current state (debug)
//   illegal_op        Op==11 seen in DECODE
//   instr_done        one-cycle pulse per retired instruction
//   instr_cnt         retired-instruction count, wraps
module multicycle_main_fsm #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       Op,
    input  logic             Funct5,
    input  logic             Funct0,
    input  logic             mem_ready,
    output logic             IRWrite,
    output logic             NextPC,
    output logic             RegW,
    output logic             MemW,
    output logic             Branch,
    output logic             AdrSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic             ALUOp,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECR    = 4'd6;
    localparam logic [3:0] EXECI    = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BRANCH   = 4'd9;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       state_q;
    logic [3:0]       state_d;
    logic [CNT_W-1:0] cnt_q;

    // Ungated strobes; the reset gate is applied at the outputs so that a
    // reset landing mid-instruction never lets a write escape.
    logic irw_raw, npc_raw, regw_raw, memw_raw, br_raw, ill_raw, done_raw;

    always_comb begin
        state_d   = FETCH;
        irw_raw   = 1'b0;
        npc_raw   = 1'b0;
        regw_raw  = 1'b0;
        memw_raw  = 1'b0;
        br_raw    = 1'b0;
        ill_raw   = 1'b0;
        done_raw  = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ALUOp     = 1'b0;
        case (state_q)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                irw_raw   = mem_ready;
                npc_raw   = mem_ready;
                state_d   = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b00:   state_d = Funct5 ? EXECI : EXECR;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: begin
                        state_d = FETCH;
                        ill_raw = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = Funct0 ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                regw_raw  = 1'b1;
                done_raw  = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                memw_raw = mem_ready;
                done_raw = mem_ready;
                state_d  = mem_ready ? FETCH : MEMWRITE;
            end
            EXECR: begin
                ALUOp   = 1'b1;
                state_d = ALUWB;
            end
            EXECI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
                state_d = ALUWB;
            end
            ALUWB: begin
                regw_raw = 1'b1;
                done_raw = 1'b1;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                br_raw    = 1'b1;
                done_raw  = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    assign IRWrite    = irw_raw  & rst_n;
    assign NextPC     = npc_raw  & rst_n;
    assign RegW       = regw_raw & rst_n;
    assign MemW       = memw_raw & rst_n;
    assign Branch     = br_raw   & rst_n;
    assign illegal_op = ill_raw  & rst_n;
    assign instr_done = done_raw & rst_n;
    assign state      = state_q;
    assign instr_cnt  = cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (done_raw) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// tb/tb_multicycle_main_fsm.sv - randomized self-checking bench for multicycle_main_fsm
module tb_multicycle_main_fsm;

    localparam int CW = 8;

    // State numbers as published for the debug port.
    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4;
    localparam int S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BRANCH = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    Op;
    logic          Funct5, Funct0, mem_ready;
    logic          IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUSrcA, ALUOp;
    logic [1:0]    ALUSrcB, ResultSrc;
    logic [3:0]    state;
    logic          illegal_op, instr_done;
    logic [CW-1:0] instr_cnt;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [CW-1:0] model_cnt;
    logic [13:0]   got_ctrl;

    multicycle_main_fsm #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .Funct5(Funct5), .Funct0(Funct0),
        .mem_ready(mem_ready), .IRWrite(IRWrite), .NextPC(NextPC), .RegW(RegW),
        .MemW(MemW), .Branch(Branch), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp), .state(state),
        .illegal_op(illegal_op), .instr_done(instr_done), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    assign got_ctrl = {IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUSrcA,
                       ALUSrcB, ResultSrc, ALUOp, illegal_op, instr_done};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Control table written straight from the per-state output list.
    function automatic logic [13:0] exp_ctrl(input int s, input logic mr,
                                             input logic [1:0] op, input logic rst);
        logic irw = 0, npc = 0, regw = 0, memw = 0, br = 0, adr = 0, sa = 0;
        logic aop = 0, ill = 0, done = 0;
        logic [1:0] sb = 2'b00, rs = 2'b00;
        case (s)
            S_FETCH:    begin sa = 1; sb = 2'b10; rs = 2'b10; irw = mr; npc = mr; end
            S_DECODE:   begin sa = 1; sb = 2'b10; rs = 2'b10; ill = (op == 2'b11); end
            S_MEMADR:   sb = 2'b01;
            S_MEMREAD:  adr = 1;
            S_MEMWB:    begin rs = 2'b01; regw = 1; done = 1; end
            S_MEMWRITE: begin adr = 1; memw = mr; done = mr; end
            S_EXECR:    aop = 1;
            S_EXECI:    begin sb = 2'b01; aop = 1; end
            S_ALUWB:    begin regw = 1; done = 1; end
            S_BRANCH:   begin sb = 2'b01; rs = 2'b10; br = 1; done = 1; end
            default:    ;
        endcase
        if (!rst) begin
            {irw, npc, regw, memw, br, ill, done} = '0;
        end
        return {irw, npc, regw, memw, br, adr, sa, sb, rs, aop, ill, done};
    endfunction

    // One instruction: build its expected state trace (with wait states), then
    // drive and check it cycle by cycle. abort_at >= 0 pulls rst_n low there.
    task automatic run_instr(input logic [1:0] op, input logic f5, input logic f0,
                             input int wf, input int wm, input int abort_at);
        int   st[$];
        logic mr[$];
        logic [13:0] e;
        for (int k = 0; k < wf; k++) begin st.push_back(S_FETCH); mr.push_back(1'b0); end
        st.push_back(S_FETCH);  mr.push_back(1'b1);
        st.push_back(S_DECODE); mr.push_back(1'($urandom));
        case (op)
            2'b00: begin
                st.push_back(f5 ? S_EXECI : S_EXECR); mr.push_back(1'($urandom));
                st.push_back(S_ALUWB);                mr.push_back(1'($urandom));
            end
            2'b01: begin
                st.push_back(S_MEMADR); mr.push_back(1'($urandom));
                for (int k = 0; k < wm; k++) begin
                    st.push_back(f0 ? S_MEMREAD : S_MEMWRITE); mr.push_back(1'b0);
                end
                st.push_back(f0 ? S_MEMREAD : S_MEMWRITE); mr.push_back(1'b1);
                if (f0) begin st.push_back(S_MEMWB); mr.push_back(1'($urandom)); end
            end
            2'b10: begin st.push_back(S_BRANCH); mr.push_back(1'($urandom)); end
            default: ;
        endcase
        for (int i = 0; i < st.size(); i++) begin
            @(posedge clk);
            #1;
            rst_n     = (i == abort_at) ? 1'b0 : 1'b1;
            mem_ready = mr[i];
            if (st[i] == S_DECODE || st[i] == S_MEMADR) begin
                Op = op; Funct5 = f5; Funct0 = f0;
            end else begin
                // Fields outside DECODE/MEMADR must be ignored.
                Op = 2'($urandom); Funct5 = 1'($urandom); Funct0 = 1'($urandom);
            end
            #1;
            e = exp_ctrl(st[i], mr[i], op, rst_n);
            check("state", 32'(state), 32'(st[i]));
            check("ctrl", 32'(got_ctrl), 32'(e));
            check("cnt", 32'(instr_cnt), 32'(model_cnt));
            if (i == abort_at) begin
                model_cnt = '0;
                return;
            end
            if (e[0]) model_cnt = model_cnt + 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b0; Op = 2'b00; Funct5 = 1'b0; Funct0 = 1'b0;
        model_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'(state), 32'(S_FETCH));
        check("reset_cnt", 32'(instr_cnt), 32'd0);
        check("reset_ctrl", 32'(got_ctrl), 32'(exp_ctrl(S_FETCH, 1'b0, 2'b00, 1'b0)));

        run_instr(2'b00, 1'b0, 1'b0, 0, 0, -1);  // ADD reg
        run_instr(2'b00, 1'b1, 1'b0, 1, 0, -1);  // ADD imm, fetch wait
        run_instr(2'b01, 1'b0, 1'b1, 0, 2, -1);  // LDR, two MEMREAD waits
        run_instr(2'b01, 1'b0, 1'b0, 0, 3, -1);  // STR, three MEMWRITE waits
        run_instr(2'b10, 1'b0, 1'b0, 0, 0, -1);  // B
        run_instr(2'b11, 1'b0, 1'b0, 0, 0, -1);  // illegal
        run_instr(2'b01, 1'b0, 1'b1, 0, 2, 3);   // reset during MEMREAD
        run_instr(2'b00, 1'b0, 1'b0, 0, 0, 3);   // reset on ALUWB: no RegW
        run_instr(2'b01, 1'b0, 1'b0, 0, 2, 4);   // reset mid store wait

        // Long run without aborts so the counter wraps through 2^CW-1 -> 0.
        for (int n = 0; n < 450; n++) begin
            run_instr(2'($urandom), 1'($urandom), 1'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 3), -1);
        end
        for (int n = 0; n < 150; n++) begin
            run_instr(2'($urandom), 1'($urandom), 1'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8)) : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
